// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with a single outstanding imem read
//
// Holds the fetch PC, issues one read at a time over a req/ack/rvalid handshake
// and registers each returned word with its PC for decode. Supports downstream
// stall (with a one-entry hold buffer), redirect/flush from branch resolution,
// and an optional fetch-time J redirect.
//
// Optional feature macro: FETCH_JUMP_EN (fetch-time jump for opcode 6'b001101).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   stall                 decode cannot accept; output register held
//   redirect, redirect_pc flush pulse and new PC from branch resolution
//   imem_req, imem_addr   read request and word-aligned byte address
//   imem_ack              request accepted this cycle
//   imem_rvalid, imem_rdata  read response
//   instr, pc_out, valid_out registered instruction, its PC, and its valid flag

module fetch_stage #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR = {6'b111111, {(WIDTH-6){1'b0}}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc_out,
    output logic             valid_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] pc_accept;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] hold_instr;
    logic [WIDTH-1:0] hold_pc;
    logic             drop;
    logic             rsp_take;
    logic             rsp_accept;
    logic             out_free;

    // A response is only meaningful while a read is outstanding. It is
    // discarded if an earlier redirect marked it stale or a redirect arrives
    // in the same cycle.
    assign rsp_take   = (state == S_WAIT) && imem_rvalid;
    assign rsp_accept = rsp_take && !drop && !redirect;
    assign out_free   = !valid_out || !stall;
    assign pc_seq     = pc + WIDTH'(4);

    always_comb begin
        pc_accept = pc_seq;
`ifdef FETCH_JUMP_EN
        // J resolves at fetch: region bits come from pc+4, target from the word.
        if (imem_rdata[31:26] == 6'b001101) begin
            pc_accept = {pc_seq[31:28], imem_rdata[25:0], 2'b00};
        end
`endif
    end

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_pc;
        end else if (rsp_accept) begin
            pc_next = pc_accept;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. HOLD doubles as the "hold buffer occupied" flag.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_take) begin
                    state_next = (rsp_accept && !out_free) ? S_HOLD : S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect || !stall) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req  = (state == S_REQ);
        imem_addr = addr_q;
    end

    // Datapath: PC, request address, drop flag, hold buffer, output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            addr_q     <= RESET_PC;
            drop       <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= '0;
            instr      <= NOP_INSTR;
            pc_out     <= '0;
            valid_out  <= 1'b0;
        end else begin
            pc <= pc_next;

            // The address is latched only when a new request starts, so a
            // redirect during an unacknowledged request leaves it untouched.
            if ((state_next == S_REQ) && (state != S_REQ)) begin
                addr_q <= pc_next;
            end

            if (rsp_take) begin
                drop <= 1'b0;
            end else if (redirect && ((state == S_REQ) || (state == S_WAIT))) begin
                drop <= 1'b1;
            end

            if (redirect) begin
                instr     <= NOP_INSTR;
                valid_out <= 1'b0;
            end else if (rsp_accept) begin
                if (out_free) begin
                    instr     <= imem_rdata;
                    pc_out    <= pc;
                    valid_out <= 1'b1;
                end else begin
                    hold_instr <= imem_rdata;
                    hold_pc    <= pc;
                end
            end else if ((state == S_HOLD) && !stall) begin
                instr     <= hold_instr;
                pc_out    <= hold_pc;
                valid_out <= 1'b1;
            end else if (!stall) begin
                instr     <= NOP_INSTR;
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage

module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'hFC00_0000;
    localparam logic [31:0] W0    = 32'h0022_1800;
    localparam logic [31:0] W1    = 32'h0422_000A;
    localparam logic [31:0] WJ    = 32'h3400_0064;
    localparam logic [31:0] WRAPA = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        valid_out;

    fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc_out     (pc_out),
        .valid_out  (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction memory contents: a few fixed words, hashed data elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return W0;
            32'h0000_0004: return W1;
            32'h0000_0008: return WJ;
            WRAPA:         return 32'h0000_0001;
            default:       return a * 32'h9E37_79B1 + 32'h1234_5678;
        endcase
    endfunction

    // Program-order successor of an instruction at pc.
    function automatic logic [31:0] next_pc_of(input logic [31:0] pc, input logic [31:0] w);
        logic [31:0] n;
        n = pc + 32'd4;
`ifdef FETCH_JUMP_EN
        if (w[31:26] == 6'b001101) n = {n[31:28], w[25:0], 2'b00};
`else
        if (w == 32'hFFFF_FFFF) n = pc + 32'd4;
`endif
        return n;
    endfunction

    // Memory model and scoreboard state
    bit          mem_busy;
    int          mem_dly;
    logic [31:0] mem_addr;
    logic [31:0] exp_pc;
    bit          p_valid, p_stall, p_redir, p_req, p_ack;
    logic [31:0] p_instr, p_pc, p_addr;
    logic [31:0] addr_log[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_instr[$];
    bit          drove_rvalid;

    // Knobs
    int          ack_pct   = 100;
    int          min_dly   = 0;
    int          max_dly   = 0;
    int          stall_pct = 0;
    int          redir_pct = 0;
    int          force_stall = 0;
    bit          redir_now = 0;
    logic [31:0] redir_tgt = 0;

    task automatic model_reset();
        mem_busy = 0; mem_dly = 0; mem_addr = 0;
        exp_pc = 32'h0;
        p_valid = 0; p_stall = 0; p_redir = 0; p_req = 0; p_ack = 0;
        p_instr = 0; p_pc = 0; p_addr = 0;
        addr_log.delete(); dlv_pc.delete(); dlv_instr.delete();
        drove_rvalid = 0;
    endtask

    // One cycle: check outputs at the negedge, then pick inputs for the next edge.
    task automatic step();
        bit busy0;
        @(negedge clk);
        if (p_redir) begin
            check("flush_valid", 32'(valid_out), 32'd0);
        end else if (p_valid && p_stall) begin
            check("freeze_valid", 32'(valid_out), 32'd1);
            check("freeze_instr", instr, p_instr);
            check("freeze_pc", pc_out, p_pc);
        end else if (valid_out) begin
            check("dlv_pc", pc_out, exp_pc);
            check("dlv_instr", instr, mem_word(exp_pc));
            dlv_pc.push_back(pc_out);
            dlv_instr.push_back(instr);
        end
        if (!valid_out) check("nop_instr", instr, NOP);
        if (p_req && !p_ack) begin
            check("req_hold", 32'(imem_req), 32'd1);
            check("addr_hold", imem_addr, p_addr);
        end
        check("one_outstanding", 32'(imem_req && mem_busy), 32'd0);
        if (imem_req) check("addr_align", 32'(imem_addr[1:0]), 32'd0);

        stall = (force_stall >= 0) ? force_stall[0] : (int'($urandom_range(99)) < stall_pct);
        redirect = redir_now || (int'($urandom_range(99)) < redir_pct);
        if (redirect) redirect_pc = redir_now ? redir_tgt : ($urandom & 32'hFFFF_FFFC);
        redir_now = 0;

        busy0 = mem_busy;
        imem_rvalid = 0; imem_ack = 0; drove_rvalid = 0;
        imem_rdata = $urandom;
        if (mem_busy) begin
            if (mem_dly == 0) begin
                imem_rvalid = 1; imem_rdata = mem_word(mem_addr);
                mem_busy = 0; drove_rvalid = 1;
            end else begin
                mem_dly--;
            end
        end
        if (!busy0 && imem_req && (int'($urandom_range(99)) < ack_pct)) begin
            imem_ack = 1;
            addr_log.push_back(imem_addr);
            mem_busy = 1; mem_addr = imem_addr;
            mem_dly = int'($urandom_range(max_dly, min_dly));
        end

        if (redirect) exp_pc = redirect_pc;
        else if (valid_out && !stall) exp_pc = next_pc_of(exp_pc, mem_word(exp_pc));
        p_valid = valid_out; p_stall = stall; p_redir = redirect;
        p_instr = instr; p_pc = pc_out; p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; stall = 0; redirect = 0; imem_ack = 0; imem_rvalid = 0;
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1;
    endtask

    task automatic run_until_dlv(input int n, input string tag);
        for (int i = 0; i < 80 && dlv_pc.size() < n; i++) step();
        check(tag, 32'(dlv_pc.size() >= n), 32'd1);
    endtask

    task automatic run_until_addrs(input int n, input string tag);
        for (int i = 0; i < 80 && addr_log.size() < n; i++) step();
        check(tag, 32'(addr_log.size() >= n), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int la, ld, ia, id;
        rst_n = 1; stall = 0; redirect = 0; redirect_pc = 0;
        imem_ack = 0; imem_rvalid = 0; imem_rdata = 0;
        model_reset();

        // Basic fetch sequence, first-word latency, J handling
        do_reset();
        for (int i = 0; i < 20 && !drove_rvalid; i++) step();
        check("t1_rvalid_seen", 32'(drove_rvalid), 32'd1);
        step();
        check("t1_lat_valid", 32'(valid_out), 32'd1);
        check("t1_lat_instr", instr, W0);
        check("t1_lat_pc", pc_out, 32'h0);
        run_until_dlv(3, "t1_three_dlv");
        run_until_addrs(4, "t1_four_addr");
        check("t1_addr0", addr_log[0], 32'h0);
        check("t1_addr1", addr_log[1], 32'h4);
        check("t1_addr2", addr_log[2], 32'h8);
`ifdef FETCH_JUMP_EN
        check("t1_addr_after_j", addr_log[3], 32'h190);
`else
        check("t1_addr_after_j", addr_log[3], 32'hC);
`endif
        check("t1_j_pc", dlv_pc[2], 32'h8);
        check("t1_j_instr", dlv_instr[2], WJ);

        // Stall with the next word parked in the hold buffer
        do_reset();
        force_stall = 1;
        run_until_dlv(1, "t2_first_dlv");
        repeat (4) step();
        check("t2_stall_noreq", 32'(imem_req), 32'd0);
        check("t2_stall_frozen", instr, W0);
        check("t2_stall_nfetch", 32'(addr_log.size()), 32'd2);
        min_dly = 2; max_dly = 2;
        force_stall = 0;
        step();
        step();
        check("t2_dlv_cnt", 32'(dlv_pc.size()), 32'd2);
        check("t2_instr", instr, W1);
        check("t2_pc", pc_out, 32'h4);
        check("t2_req", 32'(imem_req), 32'd1);
        check("t2_addr", imem_addr, 32'h8);

        // Redirect while waiting for the response at 0x8
        check("t3_in_wait", 32'(mem_busy && (mem_addr == 32'h8)), 32'd1);
        la = addr_log.size();
        ld = dlv_pc.size();
        redir_now = 1; redir_tgt = 32'h40;
        step();
        min_dly = 0; max_dly = 0;
        step();
        check("t3_flush_valid", 32'(valid_out), 32'd0);
        run_until_addrs(la + 1, "t3_refetch");
        run_until_dlv(ld + 1, "t3_redir_dlv");
        check("t3_addr", addr_log[la], 32'h40);
        check("t3_dlv_pc", dlv_pc[ld], 32'h40);

        // PC wrap at the top of the address space
        la = addr_log.size();
        ld = dlv_pc.size();
        redir_now = 1; redir_tgt = WRAPA;
        repeat (20) step();
        ia = -1;
        for (int i = la; i < addr_log.size(); i++) if (ia < 0 && addr_log[i] == WRAPA) ia = i;
        id = -1;
        for (int i = ld; i < dlv_pc.size(); i++) if (id < 0 && dlv_pc[i] == WRAPA) id = i;
        check("t4_found_addr", 32'(ia >= 0), 32'd1);
        check("t4_wrap_addr", (ia >= 0 && ia + 1 < addr_log.size()) ? addr_log[ia + 1] : 32'hDEAD_BEEF, 32'h0);
        check("t4_wrap_dlv", (id >= 0 && id + 1 < dlv_pc.size()) ? dlv_pc[id + 1] : 32'hDEAD_BEEF, 32'h0);

        // Reset in the middle of a read, with stray responses during/after reset
        min_dly = 2; max_dly = 2;
        for (int i = 0; i < 20 && !mem_busy; i++) step();
        check("t5_busy", 32'(mem_busy), 32'd1);
        @(negedge clk);
        rst_n = 0; imem_ack = 0; redirect = 0; stall = 0;
        imem_rvalid = 1; imem_rdata = $urandom;
        #1;
        check("t5_rst_valid", 32'(valid_out), 32'd0);
        check("t5_rst_instr", instr, NOP);
        check("t5_rst_req", 32'(imem_req), 32'd0);
        check("t5_rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        imem_rdata = $urandom;
        @(negedge clk);
        rst_n = 1; imem_rvalid = 1; imem_rdata = $urandom;
        model_reset();
        min_dly = 0; max_dly = 0;
        run_until_dlv(1, "t5_dlv");
        check("t5_first_addr", addr_log[0], 32'h0);
        check("t5_first_pc", dlv_pc[0], 32'h0);
        check("t5_first_instr", dlv_instr[0], W0);

        // Random traffic against the scoreboard
        ld = dlv_pc.size();
        ack_pct = 60; min_dly = 0; max_dly = 3;
        stall_pct = 30; redir_pct = 3; force_stall = -1;
        repeat (3000) step();
        check("t6_progress", 32'(dlv_pc.size() > ld + 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
